fetch_irq_stack: RTL and testbench

- Parametrised instruction-fetch PC unit: holds the PC and selects the next PC from reset, exception, sequential or branch sources.
- Adds vectored, prioritised, nestable interrupts. Pending interrupts are latched. Each interrupt line has its own vector.
- A LIFO stack of return PCs and priority levels replaces the single EPC/status-bit scheme.
- Sits at the pipeline front end and drives instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/epc_stack_chk.sv | 17 +
 rtl/fetch_irq_stack_epc_stack.sv | 63 ++++++
 rtl/fetch_irq_stack.sv | 168 ++++++++++++++++
 tb/tb_fetch_irq_stack.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch PC unit with the interrupt
// return stack: pc_sel encodings, default sizes and the return-stack entry.
package fetch_pkg;

  // pc_sel encodings
  localparam logic [1:0] PCSEL_RESET = 2'b00;
  localparam logic [1:0] PCSEL_EXC   = 2'b01;
  localparam logic [1:0] PCSEL_SEQ   = 2'b10;
  localparam logic [1:0] PCSEL_BR    = 2'b11;

  // Default configuration of the fetch unit
  localparam int ADDR_W_DEF  = 32;
  localparam int NUM_IRQ_DEF = 4;
  localparam int LEVEL_W_DEF = $clog2(NUM_IRQ_DEF + 1);

  // Priority level meaning "no interrupt in service" (one past the lowest line)
  localparam int IDLE_LEVEL  = NUM_IRQ_DEF;

  // Return-stack entry for the default configuration
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [LEVEL_W_DEF-1:0] level;
  } stack_entry_t;

endpackage

// File: rtl/epc_stack_chk.sv
// Simulation checker for epc_stack: flags a push and a pop in the same cycle.
module epc_stack_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop
);

  // A simultaneous push and pop has no defined ordering in the stack
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && pop))
        else $error("epc_stack: push and pop asserted in the same cycle");
    end
  end

endmodule

// File: rtl/fetch_irq_stack_epc_stack.sv
// epc_stack: parametrised LIFO of interrupt return entries (PC + level).
// Push when full and pop when empty are ignored; push and pop together are
// illegal and caught by epc_stack_chk.
module epc_stack import fetch_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = stack_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = $clog2(DEPTH);

  entry_t           mem_r [DEPTH];
  logic [IDX_W:0]   count_r;
  logic [IDX_W-1:0] top_idx_s;
  logic             full_s;
  logic             empty_s;

  assign full_s    = (count_r == (IDX_W+1)'(DEPTH));
  assign empty_s   = (count_r == (IDX_W+1)'(0));
  assign top_idx_s = count_r[IDX_W-1:0] - IDX_W'(1);

  // Occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= (IDX_W+1)'(0);
    end else if (push && !full_s) begin
      count_r <= count_r + (IDX_W+1)'(1);
    end else if (pop && !empty_s) begin
      count_r <= count_r - (IDX_W+1)'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage; contents are only meaningful below count_r, so no reset
  always_ff @(posedge clk) begin
    if (push && !full_s) begin
      mem_r[count_r[IDX_W-1:0]] <= din;
    end
  end

  assign top   = mem_r[top_idx_s];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

  epc_stack_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop)
  );

endmodule

// File: rtl/fetch_irq_stack.sv
// fetch_irq_stack: instruction-fetch PC unit with vectored, prioritised,
// nestable interrupts. Return PCs and preempted priority levels live on a
// LIFO (epc_stack). Optional build macro IRQ_TAIL_CHAIN_EN: an rti that finds
// a candidate above the level being restored jumps straight to the new vector
// instead of returning first.
module fetch_irq_stack import fetch_pkg::*; #(
  parameter int          ADDR_W            = ADDR_W_DEF,
  parameter int          NUM_IRQ           = NUM_IRQ_DEF,
  parameter int          STACK_DEPTH       = 4,
  parameter int          PC_INC            = 1,
  parameter int unsigned RESET_ADDRESS     = 32'h0,
  parameter int unsigned EXCEPTION_ADDRESS = 32'h100,
  parameter int unsigned VECTOR_BASE       = 32'h100,
  parameter int unsigned VECTOR_STRIDE     = 32'h10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   pc_sel,
  input  logic [ADDR_W-1:0]            pc_branch,
  input  logic [NUM_IRQ-1:0]           irq,
  input  logic [NUM_IRQ-1:0]           irq_mask,
  input  logic                         rti,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_plus_inc,
  output logic                         irq_taken,
  output logic [$clog2(NUM_IRQ)-1:0]   irq_id,
  output logic [$clog2(STACK_DEPTH):0] nest_level,
  output logic                         rti_underflow
);

  localparam int ID_W  = $clog2(NUM_IRQ);
  localparam int LVL_W = $clog2(NUM_IRQ + 1);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [LVL_W-1:0] IDLE_LVL = LVL_W'(NUM_IRQ);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [LVL_W-1:0]  level;
  } entry_t;

  logic [ADDR_W-1:0]  pc_r, pc_next_s, seq_next_s, pc_inc_s, vector_s;
  logic [NUM_IRQ-1:0] pending_r, pend_all_s, pending_next_s, clear_s;
  logic [LVL_W-1:0]   cur_level_r;
  logic [ID_W-1:0]    irq_id_r, cand_id_s;
  logic               cand_valid_s, cand_lt_s, accept_s, tail_s;
  logic               rti_act_s, pop_s;
  logic               irq_taken_r, rti_underflow_r;
  logic               full_s, empty_s;
  logic [CNT_W-1:0]   count_s;
  entry_t             push_data_s, top_s;

  assign pc_inc_s = pc_r + ADDR_W'(PC_INC);

  // Non-interrupt next PC chosen by pc_sel
  always_comb begin
    seq_next_s = pc_inc_s;
    case (pc_sel)
      PCSEL_RESET: seq_next_s = ADDR_W'(RESET_ADDRESS);
      PCSEL_EXC:   seq_next_s = ADDR_W'(EXCEPTION_ADDRESS);
      PCSEL_SEQ:   seq_next_s = pc_inc_s;
      PCSEL_BR:    seq_next_s = pc_branch;
      default:     seq_next_s = pc_inc_s;
    endcase
  end

  // Highest-priority unmasked pending line; this cycle's irq counts immediately
  always_comb begin
    pend_all_s   = pending_r | irq;
    cand_valid_s = 1'b0;
    cand_id_s    = ID_W'(0);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_all_s[i] && !irq_mask[i]) begin
        cand_valid_s = 1'b1;
        cand_id_s    = ID_W'(i);
      end else begin
        cand_valid_s = cand_valid_s;
      end
    end
  end

  // Accept, return and tail-chain decisions, pending update and next PC
  always_comb begin
    rti_act_s = !stall && rti;
    cand_lt_s = cand_valid_s && (LVL_W'(cand_id_s) < cur_level_r);
    accept_s  = !stall && !rti && cand_lt_s && !full_s;
`ifdef IRQ_TAIL_CHAIN_EN
    // Chaining keeps the top entry as is: its return PC and level are exactly
    // what a later rti must restore, so nest_level does not change.
    tail_s    = rti_act_s && !empty_s && cand_valid_s &&
                (LVL_W'(cand_id_s) < top_s.level);
`else
    tail_s    = 1'b0;
`endif
    pop_s     = rti_act_s && !empty_s && !tail_s;
    vector_s  = ADDR_W'(VECTOR_BASE) + ADDR_W'(cand_id_s) * ADDR_W'(VECTOR_STRIDE);
    clear_s   = '0;
    if (accept_s || tail_s) begin
      clear_s[cand_id_s] = 1'b1;
    end else begin
      clear_s = '0;
    end
    // A line still requesting in its accept cycle latches again
    pending_next_s = (pend_all_s & ~clear_s) | irq;
    push_data_s    = '{pc: seq_next_s, level: cur_level_r};
    if (stall) begin
      pc_next_s = pc_r;
    end else if (accept_s || tail_s) begin
      pc_next_s = vector_s;
    end else if (pop_s) begin
      pc_next_s = top_s.pc;
    end else begin
      pc_next_s = seq_next_s;
    end
  end

  // PC, pending latch, current level and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r            <= ADDR_W'(RESET_ADDRESS);
      pending_r       <= '0;
      cur_level_r     <= IDLE_LVL;
      irq_id_r        <= ID_W'(0);
      irq_taken_r     <= 1'b0;
      rti_underflow_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      pending_r   <= pending_next_s;
      irq_taken_r <= accept_s || tail_s;
      if (accept_s || tail_s) begin
        cur_level_r <= LVL_W'(cand_id_s);
        irq_id_r    <= cand_id_s;
      end else if (pop_s) begin
        cur_level_r <= top_s.level;
      end else begin
        cur_level_r <= cur_level_r;
      end
      if (rti_act_s && empty_s) begin
        rti_underflow_r <= 1'b1;
      end else begin
        rti_underflow_r <= rti_underflow_r;
      end
    end
  end

  epc_stack #(
    .DEPTH   (STACK_DEPTH),
    .entry_t (entry_t)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (push_data_s),
    .top   (top_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign pc            = pc_r;
  assign pc_plus_inc   = pc_inc_s;
  assign irq_taken     = irq_taken_r;
  assign irq_id        = irq_id_r;
  assign nest_level    = count_s;
  assign rti_underflow = rti_underflow_r;

endmodule

// File: tb/tb_fetch_irq_stack.sv
// Directed self-checking bench for fetch_irq_stack (STACK_DEPTH = 2 so the
// full-stack case is reachable with four lines). Expectations for the
// IRQ_TAIL_CHAIN_EN build are selected with the same macro.
module tb_fetch_irq_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] pc_branch;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        rti;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        irq_taken;
  logic [1:0]  irq_id;
  logic [1:0]  nest_level;
  logic        rti_underflow;

  int n_cmp = 0;
  int n_err = 0;

  fetch_irq_stack #(.STACK_DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .pc_branch     (pc_branch),
    .irq           (irq),
    .irq_mask      (irq_mask),
    .rti           (rti),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .irq_taken     (irq_taken),
    .irq_id        (irq_id),
    .nest_level    (nest_level),
    .rti_underflow (rti_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp3(input string tag, input logic [31:0] e_pc,
                      input logic [31:0] e_nest, input logic [31:0] e_taken);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".nest"}, {30'd0, nest_level}, e_nest);
    chk({tag, ".taken"}, {31'd0, irq_taken}, e_taken);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'b10; pc_branch = 32'h0;
    irq = 4'b0000; irq_mask = 4'b0000; rti = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp3("reset", 32'h0, 32'd0, 32'd0);
    chk("reset.id", {30'd0, irq_id}, 32'd0);
    chk("reset.uf", {31'd0, rti_underflow}, 32'd0);
    chk("reset.pc_plus_inc", pc_plus_inc, 32'h1);

    // Sequential fetch 1..5
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp3("seq", 32'(i), 32'd0, 32'd0);
    end

    // Direct irq[2] pulse at pc 5: vector next cycle; line re-latches
    irq = 4'b0100;
    tick(); exp3("irq2", 32'h120, 32'd1, 32'd1);
    chk("irq2.id", {30'd0, irq_id}, 32'd2);
    irq = 4'b0000; irq_mask = 4'b0100;
    tick(); exp3("irq2.body", 32'h121, 32'd1, 32'd0);
    rti = 1'b1;
    tick(); exp3("irq2.rti", 32'h6, 32'd0, 32'd0);
    rti = 1'b0;
    tick(); exp3("masked_hold", 32'h7, 32'd0, 32'd0);
    irq_mask = 4'b0000;
    tick(); exp3("unmask_take", 32'h120, 32'd1, 32'd1);
    chk("unmask_take.id", {30'd0, irq_id}, 32'd2);

    // Lower priority inside IRQ 2 does not preempt
    irq = 4'b1000;
    tick(); exp3("no_preempt", 32'h121, 32'd1, 32'd0);
    irq = 4'b0000;

    // irq[0] latched while masked, then preempts once unmasked
    irq = 4'b0001; irq_mask = 4'b0001;
    tick(); exp3("irq0.masked", 32'h122, 32'd1, 32'd0);
    irq = 4'b0000; irq_mask = 4'b0000;
    tick(); exp3("preempt", 32'h100, 32'd2, 32'd1);
    chk("preempt.id", {30'd0, irq_id}, 32'd0);
    tick(); exp3("irq0.body", 32'h101, 32'd2, 32'd0);
    rti = 1'b1;
    tick(); exp3("rti.to_irq2", 32'h123, 32'd1, 32'd0);
    rti = 1'b0;
    tick(); exp3("irq2.resume", 32'h124, 32'd1, 32'd0);

    // rti back to idle with irq[3] pending
    rti = 1'b1;
    tick();
`ifdef IRQ_TAIL_CHAIN_EN
    exp3("rti.tail3", 32'h130, 32'd1, 32'd1);
    chk("rti.tail3.id", {30'd0, irq_id}, 32'd3);
`else
    exp3("rti.to_idle", 32'h8, 32'd0, 32'd0);
`endif
    rti = 1'b0;
    tick();
`ifdef IRQ_TAIL_CHAIN_EN
    exp3("irq3.body", 32'h131, 32'd1, 32'd0);
`else
    exp3("irq3.take", 32'h130, 32'd1, 32'd1);
    chk("irq3.take.id", {30'd0, irq_id}, 32'd3);
`endif
    rti = 1'b1;
    tick();
`ifdef IRQ_TAIL_CHAIN_EN
    exp3("irq3.rti", 32'h8, 32'd0, 32'd0);
`else
    exp3("irq3.rti", 32'h9, 32'd0, 32'd0);
`endif
    rti = 1'b0;

    // Branch, exception and reset-address selections
    pc_sel = 2'b11; pc_branch = 32'h40;
    tick(); exp3("branch", 32'h40, 32'd0, 32'd0);
    pc_sel = 2'b01;
    tick(); exp3("exception", 32'h100, 32'd0, 32'd0);
    pc_sel = 2'b00;
    tick(); exp3("reset_sel", 32'h0, 32'd0, 32'd0);
    pc_sel = 2'b10;

    // Stall holds pc; irq[1] latched meanwhile is taken on release
    stall = 1'b1; irq = 4'b0010;
    tick(); exp3("stall1", 32'h0, 32'd0, 32'd0);
    irq = 4'b0000;
    tick(); exp3("stall2", 32'h0, 32'd0, 32'd0);
    stall = 1'b0;
    tick(); exp3("stall.release", 32'h110, 32'd1, 32'd1);
    chk("stall.release.id", {30'd0, irq_id}, 32'd1);
    stall = 1'b1; rti = 1'b1;
    tick(); exp3("stall.rti_ignored", 32'h110, 32'd1, 32'd0);
    stall = 1'b0;
    tick(); exp3("stall.rti_done", 32'h1, 32'd0, 32'd0);

    // rti with an empty stack
    tick(); exp3("underflow", 32'h2, 32'd0, 32'd0);
    chk("underflow.flag", {31'd0, rti_underflow}, 32'd1);
    rti = 1'b0;
    tick(); exp3("underflow.sticky", 32'h3, 32'd0, 32'd0);
    chk("underflow.sticky.flag", {31'd0, rti_underflow}, 32'd1);

    // Fill the two-deep stack (IRQ 3 then IRQ 2), then raise irq[0]
    irq = 4'b1100; irq_mask = 4'b1100;
    tick(); exp3("fill.latch", 32'h4, 32'd0, 32'd0);
    irq = 4'b0000; irq_mask = 4'b0100;
    tick(); exp3("fill.irq3", 32'h130, 32'd1, 32'd1);
    irq_mask = 4'b0000;
    tick(); exp3("fill.irq2", 32'h120, 32'd2, 32'd1);
    chk("fill.irq2.id", {30'd0, irq_id}, 32'd2);
    irq = 4'b0001;
    tick(); exp3("full.hold1", 32'h121, 32'd2, 32'd0);
    irq = 4'b0000;
    tick(); exp3("full.hold2", 32'h122, 32'd2, 32'd0);
    rti = 1'b1;
    tick();
`ifdef IRQ_TAIL_CHAIN_EN
    exp3("full.rti_tail", 32'h100, 32'd2, 32'd1);
    chk("full.rti_tail.id", {30'd0, irq_id}, 32'd0);
`else
    exp3("full.rti", 32'h131, 32'd1, 32'd0);
`endif
    rti = 1'b0;
    tick();
`ifdef IRQ_TAIL_CHAIN_EN
    exp3("full.after", 32'h101, 32'd2, 32'd0);
`else
    exp3("full.after", 32'h100, 32'd2, 32'd1);
    chk("full.after.id", {30'd0, irq_id}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
